// File: rtl/peri_pkg.sv
// Definitions shared by the AHB peripheral decoder and the peripheral response mux.
package peri_pkg;

    localparam int PERI_NSLV = 32;
    localparam int PERI_DW   = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SLV  = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } dp_state_e;

endpackage

// File: rtl/peri_default_slave.sv
// Data-phase sequencer for the peripheral region: owns the two-cycle ERROR reply
// for unmapped addresses plus the saturating error counter and last bad address.
//
//  state   | meaning
//  NONE    | no data phase pending, bus sees OKAY/ready
//  SLV     | a mapped slave owns the data phase
//  ERR1    | first ERROR cycle, HREADYOUT low
//  ERR2    | second ERROR cycle, HREADYOUT high
module peri_default_slave
    import peri_pkg::*;
#(
    parameter int ECW = 8
) (
    input  logic           HCLK,
    input  logic           HRESET,
    input  logic           req,
    input  logic           hit,
    input  logic           HREADY,
    input  logic [9:0]     HADDR,
    input  logic           ERR_CLR,
    output dp_state_e      state,
    output logic [ECW-1:0] ERR_CNT,
    output logic [9:0]     ERR_ADDR
);

    dp_state_e      state_q, state_d;
    logic [ECW-1:0] cnt_q, cnt_d;
    logic [9:0]     addr_q, addr_d;
    logic           err_entry;

    assign err_entry = (state_q != ST_ERR1) & HREADY & req & ~hit;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_ERR1) begin
            // ERR1 always moves on: HREADY is low here because we drive it low.
            state_d = ST_ERR2;
        end else if (HREADY) begin
            if (!req) begin
                state_d = ST_NONE;
            end else if (hit) begin
                state_d = ST_SLV;
            end else begin
                state_d = ST_ERR1;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (ERR_CLR) begin
            cnt_d    = '0;
            cnt_d[0] = err_entry;
        end else if (err_entry && (cnt_q != {ECW{1'b1}})) begin
            cnt_d = cnt_q + ECW'(1);
        end
        if (err_entry) begin
            addr_d = HADDR;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign state    = state_q;
    assign ERR_CNT  = cnt_q;
    assign ERR_ADDR = addr_q;

endmodule

// File: rtl/peri_resp_mux.sv
// Response-side mux for the AHB peripheral region: latches the data-phase owner,
// returns its HRDATA/HREADYOUT/HRESP, and answers unmapped accesses with ERROR.
module peri_resp_mux
    import peri_pkg::*;
#(
    parameter int NSLV = PERI_NSLV,
    parameter int DW   = PERI_DW,
    parameter int ECW  = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [1:0]       HTRANS,
    input  logic             HREADY,
    input  logic [9:0]       HADDR,
    input  logic [NSLV-1:0]  SSEL,
    input  logic [NSLV*DW-1:0] S_HRDATA,
    input  logic [NSLV-1:0]  S_HREADYOUT,
    input  logic [NSLV-1:0]  S_HRESP,
    input  logic             ERR_CLR,
    output logic [DW-1:0]    HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [ECW-1:0]   ERR_CNT,
    output logic [9:0]       ERR_ADDR
);

    logic            req;
    logic            hit;
    dp_state_e       state;
    logic [NSLV-1:0] dsel_q, dsel_d;
    logic [DW-1:0]   mux_data;
    logic            mux_rdy;
    logic            mux_resp;

    assign req = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign hit = |SSEL;

    peri_default_slave #(
        .ECW (ECW)
    ) u_dflt (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .req      (req),
        .hit      (hit),
        .HREADY   (HREADY),
        .HADDR    (HADDR),
        .ERR_CLR  (ERR_CLR),
        .state    (state),
        .ERR_CNT  (ERR_CNT),
        .ERR_ADDR (ERR_ADDR)
    );

    always_comb begin
        dsel_d = dsel_q;
        if (HREADY && (state != ST_ERR1)) begin
            dsel_d = req ? SSEL : '0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    // AND-OR mux; an illegal multi-hot select yields the OR of the chosen slaves.
    always_comb begin
        mux_data = '0;
        mux_rdy  = 1'b0;
        mux_resp = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            mux_data = mux_data | (S_HRDATA[i*DW +: DW] & {DW{dsel_q[i]}});
            mux_rdy  = mux_rdy  | (S_HREADYOUT[i] & dsel_q[i]);
            mux_resp = mux_resp | (S_HRESP[i] & dsel_q[i]);
        end
    end

    always_comb begin
        HRDATA    = '0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state)
            ST_NONE: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
            ST_SLV: begin
                HRDATA    = mux_data;
                HREADYOUT = mux_rdy;
                HRESP     = mux_resp;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: tb/tb_peri_resp_mux.sv
// Bench for peri_resp_mux: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_peri_resp_mux;
    import peri_pkg::*;

    localparam int NSLV = 32;
    localparam int DW   = 32;
    localparam int ECW  = 8;
    localparam int CMAX = (1 << ECW) - 1;

    localparam int K_NONE = 0;
    localparam int K_SLV  = 1;
    localparam int K_E1   = 2;
    localparam int K_E2   = 3;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic               HSEL;
    logic [1:0]         HTRANS;
    logic               hready_ext;
    wire                HREADY;
    logic [9:0]         HADDR;
    logic [NSLV-1:0]    SSEL;
    logic [NSLV*DW-1:0] S_HRDATA;
    logic [NSLV-1:0]    S_HREADYOUT;
    logic [NSLV-1:0]    S_HRESP;
    logic               ERR_CLR;
    logic [DW-1:0]      HRDATA;
    logic               HREADYOUT;
    logic               HRESP;
    logic [ECW-1:0]     ERR_CNT;
    logic [9:0]         ERR_ADDR;

    peri_resp_mux #(.NSLV(NSLV), .DW(DW), .ECW(ECW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HADDR       (HADDR),
        .SSEL        (SSEL),
        .S_HRDATA    (S_HRDATA),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .ERR_CLR     (ERR_CLR),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .ERR_CNT     (ERR_CNT),
        .ERR_ADDR    (ERR_ADDR)
    );

    // This block is the only data-phase responder in the region, so the bus
    // ready is its own HREADYOUT, optionally stalled by another master path.
    assign HREADY = HREADYOUT & hready_ext;

    always #5 HCLK = ~HCLK;

    int n_pass = 0;
    int n_chk  = 0;

    int              m_kind;
    logic [NSLV-1:0] m_sel;
    int              m_cnt;
    logic [9:0]      m_addr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_kind = K_NONE;
        m_sel  = '0;
        m_cnt  = 0;
        m_addr = '0;
    endtask

    task automatic model_check();
        logic [DW-1:0] ed;
        logic er, ep;
        ed = '0; er = 1'b1; ep = 1'b0;
        case (m_kind)
            K_SLV: begin
                er = 1'b0;
                for (int i = 0; i < NSLV; i++) begin
                    if (m_sel[i]) begin
                        ed = ed | S_HRDATA[i*DW +: DW];
                        er = er | S_HREADYOUT[i];
                        ep = ep | S_HRESP[i];
                    end
                end
            end
            K_E1: begin er = 1'b0; ep = 1'b1; end
            K_E2: begin er = 1'b1; ep = 1'b1; end
            default: ;
        endcase
        chk("m_hrdata", 64'(HRDATA), 64'(ed));
        chk("m_hreadyout", 64'(HREADYOUT), 64'(er));
        chk("m_hresp", 64'(HRESP), 64'(ep));
        chk("m_err_cnt", 64'(ERR_CNT), 64'(m_cnt));
        chk("m_err_addr", 64'(ERR_ADDR), 64'(m_addr));
    endtask

    task automatic model_step();
        bit inc;
        bit act;
        inc = 1'b0;
        act = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
        if (HREADY && act)
            assert ($onehot0(SSEL)) else $error("multi-hot SSEL %0h", SSEL);
        if (m_kind == K_E1) begin
            m_kind = K_E2;
        end else if (HREADY) begin
            if (!act) begin
                m_kind = K_NONE; m_sel = '0;
            end else if (SSEL != '0) begin
                m_kind = K_SLV; m_sel = SSEL;
            end else begin
                m_kind = K_E1; m_sel = '0; inc = 1'b1; m_addr = HADDR;
            end
        end
        if (ERR_CLR) m_cnt = inc ? 1 : 0;
        else if (inc && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance();
        model_check();
        model_step();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic [9:0] a,
                         input logic [NSLV-1:0] s);
        HSEL = sel; HTRANS = tr; HADDR = a; SSEL = s; ERR_CLR = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, HTRANS_IDLE, 10'h000, '0);
    endtask

    int low_cnt;

    initial begin
        HRESET = 1'b1;
        hready_ext = 1'b1;
        idle();
        S_HREADYOUT = '1;
        S_HRESP = '0;
        for (int i = 0; i < NSLV; i++) S_HRDATA[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
        model_reset();
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;

        // 1: reset release with IDLE
        settle();
        chk("rst_hreadyout", 64'(HREADYOUT), 64'h1);
        chk("rst_hresp", 64'(HRESP), 64'h0);
        chk("rst_hrdata", 64'(HRDATA), 64'h0);
        chk("rst_err_cnt", 64'(ERR_CNT), 64'h0);
        advance();

        // 2: single-cycle read from slot 2
        drive(1'b1, HTRANS_NONSEQ, 10'h002, 32'h4);
        settle(); advance();
        idle();
        settle();
        chk("rd2_hrdata", 64'(HRDATA), 64'hA5A5_0002);
        chk("rd2_hreadyout", 64'(HREADYOUT), 64'h1);
        chk("rd2_hresp", 64'(HRESP), 64'h0);
        advance();

        // 3: slot 4 with three wait states; conflicting select during the stall
        drive(1'b1, HTRANS_NONSEQ, 10'h004, 32'h10);
        settle(); advance();
        low_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            S_HREADYOUT[4] = (k < 3) ? 1'b0 : 1'b1;
            if (k == 1) drive(1'b1, HTRANS_NONSEQ, 10'h005, 32'h20);
            else idle();
            settle();
            if (!HREADYOUT) low_cnt++;
            if (k == 3) chk("ws_hrdata", 64'(HRDATA), 64'hA5A5_0004);
            if (k == 4) chk("ws_ignored_sel", 64'(HRDATA), 64'h0);
            advance();
        end
        chk("ws_low_cycles", 64'(low_cnt), 64'd3);

        // 4: unmapped access, then back-to-back unmapped from ERR2
        drive(1'b1, HTRANS_NONSEQ, 10'h07F, '0);
        settle(); advance();
        idle();
        settle();
        chk("err1_rdy_resp", 64'({HREADYOUT, HRESP}), 64'b01);
        advance();
        drive(1'b1, HTRANS_NONSEQ, 10'h155, '0);
        settle();
        chk("err2_rdy_resp", 64'({HREADYOUT, HRESP}), 64'b11);
        chk("err_cnt_1", 64'(ERR_CNT), 64'd1);
        chk("err_addr_07f", 64'(ERR_ADDR), 64'h07F);
        advance();
        idle();
        settle();
        chk("b2b_err1", 64'({HREADYOUT, HRESP}), 64'b01);
        chk("err_cnt_2", 64'(ERR_CNT), 64'd2);
        chk("err_addr_155", 64'(ERR_ADDR), 64'h155);
        advance();
        settle(); advance();
        settle();
        chk("err_done_none", 64'({HREADYOUT, HRESP}), 64'b10);
        advance();

        // 5: saturation and clear coinciding with a new error entry
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, HTRANS_SEQ, 10'(n), '0);
            settle(); advance();
            idle();
            settle(); advance();
        end
        settle();
        chk("err_cnt_sat", 64'(ERR_CNT), 64'd255);
        drive(1'b1, HTRANS_NONSEQ, 10'h2AA, '0);
        ERR_CLR = 1'b1;
        settle(); advance();
        idle();
        settle();
        chk("err_clr_inc", 64'(ERR_CNT), 64'd1);
        advance();
        settle(); advance();

        // 6: reset asserted during ERR1
        drive(1'b1, HTRANS_NONSEQ, 10'h3C3, '0);
        settle(); advance();
        idle();
        settle();
        chk("pre_rst_err1", 64'({HREADYOUT, HRESP}), 64'b01);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_err1_rdy", 64'(HREADYOUT), 64'h1);
        chk("rst_err1_resp", 64'(HRESP), 64'h0);
        chk("rst_err1_cnt", 64'(ERR_CNT), 64'h0);
        chk("rst_err1_addr", 64'(ERR_ADDR), 64'h0);
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
        settle(); advance();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [NSLV-1:0] s;
            s = '0;
            if ($urandom_range(7) != 0) s[$urandom_range(NSLV-1)] = 1'b1;
            drive(($urandom_range(3) != 0), 2'($urandom_range(3)), 10'($urandom), s);
            for (int i = 0; i < NSLV; i++) begin
                S_HRDATA[i*DW +: DW] = $urandom;
                S_HREADYOUT[i] = ($urandom_range(3) != 0);
                S_HRESP[i] = ($urandom_range(7) == 0);
            end
            hready_ext = ($urandom_range(7) != 0);
            settle();
            if (HREADY && $urandom_range(31) == 0) ERR_CLR = 1'b1;
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/peri_resp_mux.md
Name: peri_resp_mux

Overview:
Response-side companion to the peripheral address decoder in the AHB peripheral region. The decoder drives one-hot subrange selects in the address phase. This block registers which subrange owns the following data phase, muxes that slave's HRDATA/HREADYOUT/HRESP back to the bus, and acts as the default slave for unmapped peripheral addresses with a two-cycle AHB ERROR. It also keeps a saturating error counter and the last offending address block for debug.

Parameters:
NSLV, 32, number of subrange slots (width of SSEL)
DW, 32, data bus width
ECW, 8, error counter width

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous active-high reset
HSEL  in  1  peripheral-region select, address phase
HTRANS  in  2  AHB transfer type, address phase
HREADY  in  1  bus-level ready; address phase is sampled only when 1
HADDR  in  10  address bits [16:7], address phase
SSEL  in  NSLV  one-hot subrange select from the decoder, already gated by HSEL
S_HRDATA  in  NSLV*DW  slave read data, slot i at [i*DW +: DW]
S_HREADYOUT  in  NSLV  per-slave ready
S_HRESP  in  NSLV  per-slave response (1 = ERROR)
ERR_CLR  in  1  synchronous clear of ERR_CNT
HRDATA  out  DW  muxed read data
HREADYOUT  out  1  muxed ready
HRESP  out  1  muxed response
ERR_CNT  out  ECW  saturating count of unmapped accesses
ERR_ADDR  out  10  HADDR[16:7] of the most recent unmapped access

Behaviour:
- Reset is asynchronous and active-high. Under reset: state=NONE, dsel=0, ERR_CNT=0, ERR_ADDR=0, so HREADYOUT=1, HRESP=0, HRDATA=0. Reset asserted mid-transfer, including during ERR1, aborts to NONE immediately.
- Address-phase qualifier: act = HSEL & HTRANS[1] & HREADY. When HREADY=0, all registers hold.
- Data-phase FSM states: NONE, SLV, ERR1, ERR2. Register dsel[NSLV-1:0] holds the latched SSEL.
- Transitions (evaluated on HCLK edges where HREADY=1, except where stated):
  - act & |SSEL -> SLV, dsel<=SSEL.
  - act & ~|SSEL -> ERR1, dsel<=0.
  - ~act -> NONE, dsel<=0. This covers IDLE/BUSY, HSEL=0 and non-peripheral transfers.
  - ERR1 -> ERR2 unconditionally on the next edge. HREADY is necessarily 0 here because this block drives it low.
  - ERR2 completes with HREADY=1 and applies the address-phase rules above, so back-to-back transfers are supported.
- Outputs by state:
  - NONE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - SLV: AND-OR mux over dsel of S_HRDATA / S_HREADYOUT / S_HRESP. Zero added latency; the outputs are combinational from dsel.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
- Slave wait states: in SLV with S_HREADYOUT[sel]=0, dsel holds until that slave returns ready. Slave ERROR responses pass through unchanged.
- Multi-hot SSEL is illegal. The bench asserts on it; RTL output is the bitwise OR of the selected slaves.
- ERR_CNT:
  - Increments by 1 on every NONE/SLV/ERR2 -> ERR1 transition.
  - Saturates at 2^ECW-1, no wrap.
  - ERR_CLR alone -> 0. ERR_CLR together with an increment -> 1.
- ERR_ADDR loads HADDR on every transition into ERR1 and otherwise holds.

Decomposition:
- Shared package (peri_pkg) holds:
  - the AHB HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP OKAY/ERROR;
  - the FSM state encoding;
  - NSLV/DW defaults, shared with the decoder.
- One sub-module, peri_default_slave: contains the ERR1/ERR2 sequencer plus ERR_CNT/ERR_ADDR. The parent keeps dsel and the response mux.

Test Plan:
1. Reset release, HTRANS=IDLE -> HREADYOUT=1, HRESP=0, HRDATA=0, ERR_CNT=0.
2. NONSEQ read with SSEL=32'h4, S_HRDATA slot2=32'hA5A5_0002, slave ready=1 -> next cycle HRDATA=32'hA5A5_0002, HREADYOUT=1, HRESP=0.
3. NONSEQ with SSEL=32'h10, S_HREADYOUT[4]=0 for 3 cycles then 1 -> HREADYOUT low for exactly 3 cycles. A conflicting SSEL=32'h20 presented while HREADY=0 is ignored.
4. NONSEQ with HADDR=10'h07F, SSEL=0 -> cycle1 {HREADYOUT,HRESP}={0,1}, cycle2 {1,1}, then NONE. ERR_CNT=1, ERR_ADDR=10'h07F. An unmapped access immediately after ERR2 restarts at ERR1 and ERR_CNT=2.
5. 300 unmapped accesses with ECW=8 -> ERR_CNT=255. ERR_CLR pulsed in the same cycle as a new ERR1 entry -> ERR_CNT=1.
6. Assert HRESET during ERR1 -> outputs return immediately to HREADYOUT=1, HRESP=0, ERR_CNT=0, ERR_ADDR=0.
